wb_write_queue: RTL and testbench

// - Writer side of the 3-port register file write port (write_enable_rd/address_rd/write_data_rd).
// - Buffers result writebacks from variable-latency producers (load unit, multi-cycle mul/div) in a FIFO.
// - Drains one entry per cycle into the register file when the pipeline's writeback slot is free.
// - Provides bypass lookups so that decode sees queued-but-unwritten values for rs1/rs2.

---
 rtl/riscv_pkg.sv | 13 +
 rtl/wb_write_queue_if.sv | 26 ++
 rtl/wb_bypass_match.sv | 41 ++++
 rtl/wb_write_queue.sv | 121 ++++++++++++
 tb/tb_wb_write_queue.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath width, register address width and
// the writeback entry carried through the writeback queue.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/wb_write_queue_if.sv
// Producer-to-queue writeback handshake: a transfer happens when
// wb_valid && wb_ready on a rising clock edge.
interface wb_write_queue_if #(
    parameter int XLEN = riscv_pkg::XLEN
) ();

    logic                             wb_valid;
    logic                             wb_ready;
    logic [riscv_pkg::REG_ADDR_W-1:0] wb_rd;
    logic [XLEN-1:0]                  wb_data;

    modport master (
        output wb_valid,
        output wb_rd,
        output wb_data,
        input  wb_ready
    );

    modport slave (
        input  wb_valid,
        input  wb_rd,
        input  wb_data,
        output wb_ready
    );

endinterface

// File: rtl/wb_bypass_match.sv
// Searches the queued writebacks for one register address; among several
// matches the youngest (closest to the tail) supplies the bypass value.
module wb_bypass_match
    import riscv_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = PTR_W + 1
) (
    input  wb_entry_t             entries [DEPTH],
    input  logic [PTR_W-1:0]      head,
    input  logic [OCC_W-1:0]      occupancy,
    input  logic [REG_ADDR_W-1:0] lookup,
    output logic                  hit,
    output logic [XLEN-1:0]       value
);

    logic [DEPTH-1:0] match;
    logic [XLEN-1:0]  data_at [DEPTH];

    // Index gi is the age offset from the head: 0 is oldest, occupancy-1 youngest.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
        logic [PTR_W-1:0] slot;
        assign slot        = head + PTR_W'(gi);
        assign match[gi]   = (OCC_W'(gi) < occupancy)
                           && (entries[slot].rd == lookup)
                           && (lookup != '0);
        assign data_at[gi] = entries[slot].data;
    end

    always_comb begin
        hit   = |match;
        value = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (match[i]) begin
                value = data_at[i];
            end
        end
    end

endmodule

// File: rtl/wb_write_queue.sv
// FIFO of pending register-file writebacks from variable-latency units, drained
// one entry per free writeback slot, with rs1/rs2 bypass of queued values.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = riscv_pkg::XLEN
) (
    input  logic                                   clk,
    input  logic                                   reset,
    wb_write_queue_if.slave                        wb,
    input  logic                                   drain_enable,
    output logic                                   write_enable_rd,
    output logic [riscv_pkg::REG_ADDR_W-1:0]       address_rd,
    output logic [XLEN-1:0]                        write_data_rd,
    input  logic [riscv_pkg::REG_ADDR_W-1:0]       lookup_rs1,
    input  logic [riscv_pkg::REG_ADDR_W-1:0]       lookup_rs2,
    output logic                                   hit_rs1,
    output logic                                   hit_rs2,
    output logic [XLEN-1:0]                        bypass_rs1,
    output logic [XLEN-1:0]                        bypass_rs2,
    output logic [$clog2(DEPTH):0]                 occupancy
);
    import riscv_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    wb_entry_t        entries_reg [DEPTH];
    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [OCC_W-1:0] occ_reg, occ_next;

    logic             ready;
    logic             push;
    logic             pop;
    logic [DEPTH-1:0] slot_we;
    wb_entry_t        head_entry;

    // Ready depends only on stored occupancy, so a pop never frees a slot
    // for a same-cycle push; reset holds it high.
    assign ready       = reset || (occ_reg != OCC_W'(DEPTH));
    assign wb.wb_ready = ready;

    // x0 writebacks complete the handshake but are dropped.
    assign push = !reset && wb.wb_valid && ready && (wb.wb_rd != '0);
    assign pop  = !reset && drain_enable && (occ_reg != '0);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        assign slot_we[gi] = push && (tail_reg == PTR_W'(gi));
    end

    always_comb begin
        head_next = head_reg;
        tail_next = tail_reg;
        occ_next  = occ_reg;
        if (push) begin
            tail_next = tail_reg + 1'b1;
        end
        if (pop) begin
            head_next = head_reg + 1'b1;
        end
        case ({push, pop})
            2'b10:   occ_next = occ_reg + 1'b1;
            2'b01:   occ_next = occ_reg - 1'b1;
            default: occ_next = occ_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg <= '0;
            tail_reg <= '0;
            occ_reg  <= '0;
        end else begin
            head_reg <= head_next;
            tail_reg <= tail_next;
            occ_reg  <= occ_next;
        end
    end

    // Payload flops need no reset: occupancy alone defines which slots are live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_we[i]) begin
                entries_reg[i] <= '{rd: wb.wb_rd, data: wb.wb_data};
            end
        end
    end

    assign head_entry      = entries_reg[head_reg];
    assign write_enable_rd = pop;
    assign address_rd      = pop ? head_entry.rd   : '0;
    assign write_data_rd   = pop ? head_entry.data : '0;
    assign occupancy       = occ_reg;

    logic            hit1_raw, hit2_raw;
    logic [XLEN-1:0] val1_raw, val2_raw;

    wb_bypass_match #(.DEPTH(DEPTH)) u_match_rs1 (
        .entries   (entries_reg),
        .head      (head_reg),
        .occupancy (occ_reg),
        .lookup    (lookup_rs1),
        .hit       (hit1_raw),
        .value     (val1_raw)
    );

    wb_bypass_match #(.DEPTH(DEPTH)) u_match_rs2 (
        .entries   (entries_reg),
        .head      (head_reg),
        .occupancy (occ_reg),
        .lookup    (lookup_rs2),
        .hit       (hit2_raw),
        .value     (val2_raw)
    );

    assign hit_rs1    = hit1_raw && !reset;
    assign hit_rs2    = hit2_raw && !reset;
    assign bypass_rs1 = reset ? '0 : val1_raw;
    assign bypass_rs2 = reset ? '0 : val2_raw;

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: a scoreboard queue holds every accepted
// writeback and is checked against the write port and bypass outputs.
module tb_wb_write_queue;
    import riscv_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        drain_enable;
    logic        write_enable_rd;
    logic [4:0]  address_rd;
    logic [31:0] write_data_rd;
    logic [4:0]  lookup_rs1, lookup_rs2;
    logic        hit_rs1, hit_rs2;
    logic [31:0] bypass_rs1, bypass_rs2;
    logic [2:0]  occupancy;

    wb_write_queue_if #(.XLEN(32)) wb ();

    wb_write_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .wb              (wb.slave),
        .drain_enable    (drain_enable),
        .write_enable_rd (write_enable_rd),
        .address_rd      (address_rd),
        .write_data_rd   (write_data_rd),
        .lookup_rs1      (lookup_rs1),
        .lookup_rs2      (lookup_rs2),
        .hit_rs1         (hit_rs1),
        .hit_rs2         (hit_rs2),
        .bypass_rs1      (bypass_rs1),
        .bypass_rs2      (bypass_rs2),
        .occupancy       (occupancy)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    wb_entry_t   sb [$];
    logic [31:0] rf [32];
    bit          accepted;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_bypass(input logic [4:0] rs, output logic hit, output logic [31:0] val);
        hit = 1'b0;
        val = '0;
        if (rs != 5'd0) begin
            foreach (sb[i]) begin
                if (sb[i].rd == rs) begin
                    hit = 1'b1;
                    val = sb[i].data;
                end
            end
        end
    endfunction

    task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] d, input logic dr);
        wb.wb_valid  = v;
        wb.wb_rd     = rd;
        wb.wb_data   = d;
        drain_enable = dr;
    endtask

    // Checks the current cycle against the scoreboard, then advances one clock.
    task automatic cycle();
        logic        eh1, eh2;
        logic [31:0] ev1, ev2;
        wb_entry_t   e;
        #2;
        model_bypass(lookup_rs1, eh1, ev1);
        model_bypass(lookup_rs2, eh2, ev2);
        if (reset) begin
            eh1 = 1'b0; ev1 = '0; eh2 = 1'b0; ev2 = '0;
        end
        check("wb_ready", 32'(wb.wb_ready), 32'(reset || sb.size() < DEPTH));
        if (!reset) check("occupancy", 32'(occupancy), 32'(sb.size()));
        check("hit_rs1", 32'(hit_rs1), 32'(eh1));
        check("bypass_rs1", bypass_rs1, ev1);
        check("hit_rs2", 32'(hit_rs2), 32'(eh2));
        check("bypass_rs2", bypass_rs2, ev2);
        check("write_enable", 32'(write_enable_rd), 32'(!reset && drain_enable && sb.size() != 0));
        if (write_enable_rd && sb.size() != 0) begin
            e = sb.pop_front();
            check("write_addr", 32'(address_rd), 32'(e.rd));
            check("write_data", write_data_rd, e.data);
            rf[address_rd] = write_data_rd;
            $display("[TB] regfile write x%0d = %h", address_rd, write_data_rd);
        end else begin
            check("idle_addr", 32'(address_rd), 32'd0);
            check("idle_data", write_data_rd, 32'd0);
        end
        accepted = wb.wb_valid && wb.wb_ready;
        if (!reset && accepted && wb.wb_rd != 5'd0) begin
            sb.push_back('{rd: wb.wb_rd, data: wb.wb_data});
            $display("[TB] push x%0d = %h", wb.wb_rd, wb.wb_data);
        end
        if (reset) sb.delete();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        foreach (rf[i]) rf[i] = '0;
        reset = 1'b1;
        lookup_rs1 = '0;
        lookup_rs2 = '0;
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        @(negedge clk);
        cycle();
        cycle();
        reset = 1'b0;
        #1;
        check("reset_occ", 32'(occupancy), 32'd0);
        check("reset_ready", 32'(wb.wb_ready), 32'd1);
        cycle();

        // Single entry: bypass while queued, then drain.
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
        cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        lookup_rs1 = 5'd5;
        #1;
        check("t1_occ", 32'(occupancy), 32'd1);
        check("t1_hit", 32'(hit_rs1), 32'd1);
        check("t1_bypass", bypass_rs1, 32'hDEADBEEF);
        cycle();
        drain_enable = 1'b1;
        #1;
        check("t1_we", 32'(write_enable_rd), 32'd1);
        check("t1_addr", 32'(address_rd), 32'd5);
        cycle();
        drain_enable = 1'b0;
        check("t1_occ_after", 32'(occupancy), 32'd0);
        cycle();

        // Fill to capacity, hold a fifth offer, then drain in order.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'(i), 32'h1000 + 32'(i), 1'b0);
            lookup_rs2 = 5'(i);
            cycle();
        end
        drive(1'b1, 5'd6, 32'h66, 1'b0);
        #1;
        check("t2_full_ready", 32'(wb.wb_ready), 32'd0);
        cycle();
        cycle();
        drain_enable = 1'b1;
        #1;
        check("t2_ready_during_pop", 32'(wb.wb_ready), 32'd0);
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (accepted) wb.wb_valid = 1'b0;
        end
        check("t2_fifth_accepted", 32'(rf[6]), 32'h66);
        check("t2_empty", 32'(occupancy), 32'd0);
        drain_enable = 1'b0;

        // Same destination twice: youngest wins in bypass and regfile.
        drive(1'b1, 5'd3, 32'd1, 1'b0);
        cycle();
        drive(1'b1, 5'd3, 32'd2, 1'b0);
        cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        lookup_rs1 = 5'd3;
        lookup_rs2 = 5'd3;
        #1;
        check("t3_bypass", bypass_rs1, 32'd2);
        cycle();
        drain_enable = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        check("t3_x3", rf[3], 32'd2);

        // x0 writeback is accepted but never queued.
        drive(1'b1, 5'd0, 32'hFFFF, 1'b1);
        lookup_rs1 = 5'd0;
        #1;
        check("t4_ready", 32'(wb.wb_ready), 32'd1);
        cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b1);
        cycle();
        check("t4_occ", 32'(occupancy), 32'd0);
        check("t4_x0", rf[0], 32'd0);

        // Steady push+pop at occupancy 2 across pointer wrap.
        drive(1'b1, 5'd10, 32'hA0A0_0001, 1'b0);
        cycle();
        drive(1'b1, 5'd11, 32'hA0A0_0002, 1'b0);
        cycle();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1);
            lookup_rs1 = sb[sb.size()-1].rd;
            lookup_rs2 = 5'($urandom_range(0, 31));
            cycle();
            check("t5_occ_const", 32'(occupancy), 32'd2);
        end

        // Reset with pending entries discards them.
        drive(1'b1, 5'd20, 32'h2020, 1'b0);
        cycle();
        check("t6_occ3", 32'(occupancy), 32'd3);
        reset = 1'b1;
        drive(1'b1, 5'd21, 32'h2121, 1'b1);
        lookup_rs1 = 5'd20;
        #1;
        check("t6_we_in_reset", 32'(write_enable_rd), 32'd0);
        cycle();
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        #1;
        check("t6_occ", 32'(occupancy), 32'd0);
        check("t6_hit", 32'(hit_rs1), 32'd0);
        check("t6_ready", 32'(wb.wb_ready), 32'd1);
        cycle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
